// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the synthesizer register file slice.
package reg_file_pkg;
   localparam int DW_DEF       = 16;
   localparam int NREG_DEF     = 16;
   localparam int NPWM_DEF     = 8;
   localparam int PWM_BASE_DEF = 8;
   localparam int I2C_REG_DEF  = 6;

   localparam int I2C_STS_LSB  = 8;
   localparam int I2C_STS_MSB  = 9;

   // True when addr lands in the PWM shadow window [base, base+n).
   function automatic logic is_pwm_addr(input logic [31:0] addr,
                                        input int unsigned base = PWM_BASE_DEF,
                                        input int unsigned n    = NPWM_DEF);
      return (addr >= base) && (addr < base + n);
   endfunction
endpackage

// File: rtl/reg_file_p_if.sv
// Core / I2C / PWM-timebase side bundle for reg_file_p.
interface reg_file_p_if #(
   parameter int DW   = 16,
   parameter int AW   = 4,
   parameter int NPWM = 8
);
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [AW-1:0]     raddr_a, raddr_b, raddr_c;
   logic [DW-1:0]     rdata_a, rdata_b, rdata_c;
   logic              i2c_sts_we;
   logic [1:0]        i2c_sts;
   logic [8:0]        i2c_addr;
   logic              pwm_commit;
   logic              pwm_pending;
   logic [NPWM*DW-1:0] pwm_out;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b, raddr_c,
             i2c_sts_we, i2c_sts, pwm_commit,
      input  rdata_a, rdata_b, rdata_c, i2c_addr, pwm_pending, pwm_out
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b, raddr_c,
             i2c_sts_we, i2c_sts, pwm_commit,
      output rdata_a, rdata_b, rdata_c, i2c_addr, pwm_pending, pwm_out
   );
endinterface

// File: rtl/reg_file_p_pwm_shadow_bank.sv
// Active PWM bank: copies the whole shadow window at once on a commit strobe
// so a multi-channel update never lands mid-frame.
module pwm_shadow_bank #(
   parameter int DW   = 16,
   parameter int NPWM = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_commit,
   input  logic               i_win_we,
   input  logic [NPWM*DW-1:0] i_shadow,
   output logic [NPWM*DW-1:0] o_active,
   output logic               o_pending
);
   logic [NPWM-1:0][DW-1:0] r_active;
   logic                    r_pending;
   logic                    w_take;

   assign w_take = i_commit & r_pending;

   for (genvar k = 0; k < NPWM; k++) begin : g_ch
      always_ff @(posedge clk) begin
         if (rst)         r_active[k] <= '0;
         else if (w_take) r_active[k] <= i_shadow[k*DW +: DW];
      end
      assign o_active[k*DW +: DW] = r_active[k];
   end

   // A window write in the commit cycle re-arms pending; the write beats the clear.
   always_ff @(posedge clk) begin
      if (rst) r_pending <= 1'b0;
      else     r_pending <= i_win_we | (r_pending & ~i_commit);
   end

   assign o_pending = r_pending;
endmodule

// File: rtl/reg_file_p.sv
// Register file with R0=0, 3 bypassed read ports, merged I2C status register
// and a double-buffered PWM channel window.
module reg_file_p
   import reg_file_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int AW       = $clog2(NREG),
   parameter int NPWM     = NPWM_DEF,
   parameter int PWM_BASE = PWM_BASE_DEF,
   parameter int I2C_REG  = I2C_REG_DEF
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_p_if.slave   bus
);
   logic [NREG-1:0][DW-1:0] r_regs;
   logic                    w_wr;
   logic                    w_wr_i2c;
   logic                    w_win_we;
   logic [DW-1:0]           w_wval;
   logic [NPWM*DW-1:0]      w_shadow;

   assign w_wr     = bus.we && (bus.waddr != '0);
   assign w_wr_i2c = w_wr && (bus.waddr == AW'(I2C_REG));
   assign w_win_we = w_wr && is_pwm_addr(32'(bus.waddr), PWM_BASE, NPWM);

   // Status bits always override core data on the I2C register, storage and bypass alike.
   always_comb begin
      w_wval = bus.wdata;
      if (w_wr_i2c && bus.i2c_sts_we)
         w_wval[I2C_STS_MSB:I2C_STS_LSB] = bus.i2c_sts;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_regs <= '0;
      end else begin
         if (w_wr)
            r_regs[bus.waddr] <= w_wval;
         if (bus.i2c_sts_we)
            r_regs[I2C_REG][I2C_STS_MSB:I2C_STS_LSB] <= bus.i2c_sts;
      end
   end

   assign bus.rdata_a = (w_wr && bus.waddr == bus.raddr_a) ? w_wval : r_regs[bus.raddr_a];
   assign bus.rdata_b = (w_wr && bus.waddr == bus.raddr_b) ? w_wval : r_regs[bus.raddr_b];
   assign bus.rdata_c = (w_wr && bus.waddr == bus.raddr_c) ? w_wval : r_regs[bus.raddr_c];

   assign bus.i2c_addr = r_regs[I2C_REG][8:0];

   for (genvar k = 0; k < NPWM; k++) begin : g_sh
      assign w_shadow[k*DW +: DW] = r_regs[PWM_BASE+k];
   end

   pwm_shadow_bank #(.DW(DW), .NPWM(NPWM)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_commit  (bus.pwm_commit),
      .i_win_we  (w_win_we),
      .i_shadow  (w_shadow),
      .o_active  (bus.pwm_out),
      .o_pending (bus.pwm_pending)
   );
endmodule

// File: tb/tb_reg_file_p.sv
// Directed scenarios plus a randomized run against an array-based model.
module tb_reg_file_p;
   localparam int DW = 16, NREG = 16, AW = 4, NPWM = 8, PB = 8, IR = 6;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] m_reg [NREG];
   logic [DW-1:0] m_act [NPWM];
   bit            m_pend;

   reg_file_p_if #(.DW(DW), .AW(AW), .NPWM(NPWM)) bus();

   reg_file_p #(.DW(DW), .NREG(NREG), .NPWM(NPWM), .PWM_BASE(PB), .I2C_REG(IR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] wval();
      logic [DW-1:0] v;
      v = bus.wdata;
      if (bus.waddr == 4'(IR) && bus.i2c_sts_we) v[9:8] = bus.i2c_sts;
      return v;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (bus.we && bus.waddr != 0 && bus.waddr == a) return wval();
      if (a == 0) return '0;
      return m_reg[a];
   endfunction

   function automatic logic [NPWM*DW-1:0] exp_pwm();
      logic [NPWM*DW-1:0] v;
      for (int k = 0; k < NPWM; k++) v[k*DW +: DW] = m_act[k];
      return v;
   endfunction

   // Advance one clock, applying the behavioural rules to the model first.
   task automatic tick();
      logic [DW-1:0] sh [NPWM];
      bit np;
      if (rst) begin
         for (int i = 0; i < NREG; i++) m_reg[i] = '0;
         for (int k = 0; k < NPWM; k++) m_act[k] = '0;
         m_pend = 0;
      end else begin
         for (int k = 0; k < NPWM; k++) sh[k] = m_reg[PB+k];
         if (bus.pwm_commit && m_pend)
            for (int k = 0; k < NPWM; k++) m_act[k] = sh[k];
         np = m_pend && !bus.pwm_commit;
         if (bus.we && bus.waddr != 0) begin
            m_reg[bus.waddr] = wval();
            if (int'(bus.waddr) >= PB && int'(bus.waddr) < PB + NPWM) np = 1;
         end
         if (bus.i2c_sts_we) m_reg[IR][9:8] = bus.i2c_sts;
         m_pend = np;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.we = 0; bus.waddr = '0; bus.wdata = '0;
      bus.i2c_sts_we = 0; bus.i2c_sts = '0; bus.pwm_commit = 0;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d, input bit commit);
      idle();
      bus.we = 1; bus.waddr = AW'(a); bus.wdata = d; bus.pwm_commit = commit;
      tick();
      idle();
   endtask

   task automatic commit();
      idle(); bus.pwm_commit = 1; tick(); idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      bus.we = 1; bus.waddr = 4'd9; bus.wdata = 16'hAAAA; bus.pwm_commit = 1;
      tick(); tick();
      rst = 0; idle();
      bus.raddr_a = 4'd6; bus.raddr_b = 4'd9; bus.raddr_c = 4'd1; #1;
      checks++; if (bus.rdata_a !== 16'h0 || bus.rdata_b !== 16'h0 || bus.rdata_c !== 16'h0) begin
         errors++; $display("FAIL reset_rdata got %h %h %h want 0", bus.rdata_a, bus.rdata_b, bus.rdata_c); end
      checks++; if (bus.i2c_addr !== 9'h0) begin errors++; $display("FAIL reset_i2c got %h want 0", bus.i2c_addr); end
      checks++; if (bus.pwm_out !== '0 || bus.pwm_pending !== 1'b0) begin
         errors++; $display("FAIL reset_pwm got %h pend %b want 0/0", bus.pwm_out, bus.pwm_pending); end
   endtask

   task automatic test_basic();
      wr(5, 16'hBEEF, 0);
      bus.raddr_a = 4'd5; bus.raddr_b = 4'd0; bus.raddr_c = 4'd5; #1;
      checks++; if (bus.rdata_a !== 16'hBEEF || bus.rdata_b !== 16'h0 || bus.rdata_c !== 16'hBEEF) begin
         errors++; $display("FAIL basic_rd got %h %h %h want beef 0 beef", bus.rdata_a, bus.rdata_b, bus.rdata_c); end
      bus.we = 1; bus.waddr = 4'd0; bus.wdata = 16'hFFFF; bus.raddr_b = 4'd0; #1;
      checks++; if (bus.rdata_b !== 16'h0) begin errors++; $display("FAIL r0_bypass got %h want 0", bus.rdata_b); end
      tick(); idle(); #1;
      checks++; if (bus.rdata_b !== 16'h0) begin errors++; $display("FAIL r0_store got %h want 0", bus.rdata_b); end
   endtask

   task automatic test_bypass();
      bus.we = 1; bus.waddr = 4'd3; bus.wdata = 16'h1234; bus.raddr_a = 4'd3; bus.raddr_b = 4'd5; #1;
      checks++; if (bus.rdata_a !== 16'h1234 || bus.rdata_b !== 16'hBEEF) begin
         errors++; $display("FAIL bypass got %h %h want 1234 beef", bus.rdata_a, bus.rdata_b); end
      tick(); idle();
   endtask

   task automatic test_i2c_merge();
      bus.we = 1; bus.waddr = 4'd6; bus.wdata = 16'h01FF;
      bus.i2c_sts_we = 1; bus.i2c_sts = 2'b10; bus.raddr_c = 4'd6; #1;
      checks++; if (bus.rdata_c !== 16'h02FF) begin errors++; $display("FAIL i2c_bypass got %h want 02ff", bus.rdata_c); end
      tick(); idle(); #1;
      checks++; if (bus.rdata_c !== 16'h02FF || bus.i2c_addr !== 9'h0FF) begin
         errors++; $display("FAIL i2c_merge got %h addr %h want 02ff 0ff", bus.rdata_c, bus.i2c_addr); end
      bus.i2c_sts_we = 1; bus.i2c_sts = 2'b01; tick(); idle(); #1;
      checks++; if (bus.rdata_c !== 16'h01FF || bus.i2c_addr !== 9'h1FF) begin
         errors++; $display("FAIL i2c_sts got %h addr %h want 01ff 1ff", bus.rdata_c, bus.i2c_addr); end
   endtask

   task automatic test_pwm_tearfree();
      for (int k = 0; k < NPWM; k++) wr(PB + k, 16'(100 + k), 0);
      checks++; if (bus.pwm_out !== '0 || bus.pwm_pending !== 1'b1) begin
         errors++; $display("FAIL pwm_shadow got %h pend %b want 0/1", bus.pwm_out, bus.pwm_pending); end
      commit();
      for (int k = 0; k < NPWM; k++) begin
         checks++; if (bus.pwm_out[k*DW +: DW] !== 16'(100 + k)) begin
            errors++; $display("FAIL pwm_commit ch%0d got %0d want %0d", k, bus.pwm_out[k*DW +: DW], 100 + k); end
      end
      checks++; if (bus.pwm_pending !== 1'b0) begin errors++; $display("FAIL pwm_pend_clr got %b want 0", bus.pwm_pending); end
      commit();
      checks++; if (bus.pwm_out[2*DW +: DW] !== 16'd102) begin
         errors++; $display("FAIL pwm_idle_commit got %0d want 102", bus.pwm_out[2*DW +: DW]); end
   endtask

   task automatic test_collision();
      wr(PB + 2, 16'd5, 0); commit();
      wr(PB + 0, 16'd1, 0);
      wr(PB + 2, 16'd9, 1);
      checks++; if (bus.pwm_out[2*DW +: DW] !== 16'd5 || bus.pwm_pending !== 1'b1) begin
         errors++; $display("FAIL collide got %0d pend %b want 5/1", bus.pwm_out[2*DW +: DW], bus.pwm_pending); end
      commit();
      checks++; if (bus.pwm_out[2*DW +: DW] !== 16'd9 || bus.pwm_pending !== 1'b0) begin
         errors++; $display("FAIL collide_next got %0d pend %b want 9/0", bus.pwm_out[2*DW +: DW], bus.pwm_pending); end
   endtask

   task automatic test_reset_midframe();
      wr(PB + 4, 16'h7777, 0);
      rst = 1; tick(); rst = 0;
      checks++; if (bus.pwm_out !== '0 || bus.pwm_pending !== 1'b0) begin
         errors++; $display("FAIL rst_mid got %h pend %b want 0/0", bus.pwm_out, bus.pwm_pending); end
      commit();
      checks++; if (bus.pwm_out !== '0) begin errors++; $display("FAIL rst_mid_commit got %h want 0", bus.pwm_out); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         bus.we = $urandom_range(0, 3) != 0;
         bus.waddr = ($urandom_range(0, 3) == 0) ? 4'(IR) : AW'($urandom);
         bus.wdata = DW'($urandom);
         bus.raddr_a = AW'($urandom); bus.raddr_b = AW'($urandom);
         bus.raddr_c = ($urandom_range(0, 1) == 1) ? bus.waddr : AW'($urandom);
         bus.i2c_sts_we = $urandom_range(0, 2) == 0;
         bus.i2c_sts = 2'($urandom);
         bus.pwm_commit = $urandom_range(0, 4) == 0;
         #1;
         checks++; if (bus.rdata_a !== exp_rd(bus.raddr_a) || bus.rdata_b !== exp_rd(bus.raddr_b) ||
                       bus.rdata_c !== exp_rd(bus.raddr_c)) begin
            errors++; $display("FAIL rand_rd n%0d got %h %h %h want %h %h %h", n, bus.rdata_a, bus.rdata_b,
                               bus.rdata_c, exp_rd(bus.raddr_a), exp_rd(bus.raddr_b), exp_rd(bus.raddr_c)); end
         checks++; if (bus.i2c_addr !== m_reg[IR][8:0]) begin
            errors++; $display("FAIL rand_i2c n%0d got %h want %h", n, bus.i2c_addr, m_reg[IR][8:0]); end
         checks++; if (bus.pwm_out !== exp_pwm() || bus.pwm_pending !== m_pend) begin
            errors++; $display("FAIL rand_pwm n%0d got %h/%b want %h/%b", n, bus.pwm_out, bus.pwm_pending,
                               exp_pwm(), m_pend); end
         tick();
      end
      rst = 0; idle();
   endtask

   initial begin
      rst = 1; idle();
      bus.raddr_a = '0; bus.raddr_b = '0; bus.raddr_c = '0;
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      for (int k = 0; k < NPWM; k++) m_act[k] = '0;
      m_pend = 0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_bypass();
      test_i2c_merge();
      test_pwm_tearfree();
      test_collision();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_file_p.md
# reg_file_p

Parametrised register file for the synthesizer datapath: R0 reads as zero; general-purpose registers feed three combinational read ports with write-through bypass. It adds two functions: a memory-mapped I2C control/status register, and a window of PWM channel registers. The window is double-buffered: the PWM outputs change only on a frame-aligned commit strobe, so a multi-channel update never produces a torn audio frame. It sits between the core's decode/execute stage, the I2C master and the PWM bank.

## Interface
Parameters:
- DW, 16, data/register width (≥ 10)
- NREG, 16, number of registers including R0 (power of two, ≥ 4)
- AW, $clog2(NREG), register address width
- NPWM, 8, number of PWM channels
- PWM_BASE, 8, index of first PWM register; PWM_BASE + NPWM ≤ NREG, PWM_BASE ≥ 1
- I2C_REG, 6, index of the I2C control/status register, outside the PWM window

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  core write enable
- waddr  in  AW  core write address
- wdata  in  DW  core write data
- raddr_a, raddr_b, raddr_c  in  AW each  read addresses
- rdata_a, rdata_b, rdata_c  out  DW each  read data
- i2c_sts_we  in  1  I2C status update strobe
- i2c_sts  in  2  I2C status value
- i2c_addr  out  9  I2C_REG[8:0]
- pwm_commit  in  1  frame strobe from the PWM timebase
- pwm_pending  out  1  shadow holds uncommitted writes
- pwm_out  out  NPWM*DW  active PWM values, channel k at [k*DW +: DW]

## Operation
- Storage: R1..R(NREG-1), DW bits each. Writes to R0 are ignored; reads of R0 return 0.
- Reads are combinational.
  - If we=1, waddr≠0 and waddr==raddr_x, rdata_x = wdata (write-through bypass).
  - Otherwise rdata_x = R[raddr_x].
- Core write: on a clock edge with we=1 and waddr≠0, R[waddr] ← wdata.
- I2C status: when i2c_sts_we=1, R[I2C_REG][9:8] ← i2c_sts. Other bits are unchanged.
  - If a core write to I2C_REG occurs in the same cycle, the register takes wdata with bits [9:8] replaced by i2c_sts. Status always wins on those two bits.
  - The bypass path applies the same merge.
  - i2c_addr is continuous, and reflects the register one cycle after the write.
- PWM shadow/active:
  - R[PWM_BASE+k] is the shadow for channel k. A separate active bank A[k] drives pwm_out.
  - Any core write into the PWM window sets pending.
  - When pwm_commit=1 and pending=1: all A[k] ← R[PWM_BASE+k] simultaneously, and pending clears.
  - pwm_commit with pending=0 has no effect.
- Same cycle as commit, a PWM-window write is not captured: commit copies pre-edge shadow values.
  - That write updates its shadow register and leaves pending=1 after the edge. The write wins over the clear.
- pwm_pending is the registered pending flag.
- Reset: all R, all A, and pending ← 0. So all rdata_x = 0 (absent bypass), i2c_addr = 0, pwm_out = 0, pwm_pending = 0.
  - Reset overrides we, i2c_sts_we and pwm_commit in the same cycle.
  - Reset mid-frame discards uncommitted shadow writes.

## Timing
- Read latency 0 (combinational, including bypass).
- Write visible through storage on the cycle after the edge.
- PWM write → pwm_out: at the first pwm_commit edge after the write cycle. Minimum 1 cycle, if commit is asserted the next cycle.
- pwm_pending rises the cycle after the first PWM-window write and falls the cycle after a consuming commit.
- No backpressure. All inputs are sampled every clock edge.

## Structure
- Shared package reg_file_pkg holds:
  - default parameter constants (DW, NREG, PWM_BASE, NPWM, I2C_REG);
  - the status bit positions (I2C_STS_LSB=8, I2C_STS_MSB=9);
  - function is_pwm_addr(addr).
- One sub-module, pwm_shadow_bank: active bank, pending flag, commit logic. Parameterised by DW/NPWM; inputs are the flattened shadow vector and a window-write strobe.
- Read muxes and bypass stay in the top level.

## Test plan
- Reset, then R5←16'hBEEF; read A=5, B=0, C=5 → A=C=16'hBEEF, B=0. Write to R0 → reads of R0 remain 0.
- Bypass: we=1, waddr=3, wdata=16'h1234, raddr_a=3 same cycle → rdata_a=16'h1234 that cycle.
- I2C merge: core writes R6←16'h01FF while i2c_sts_we=1 with i2c_sts=2'b10 → R6=16'h02FF, i2c_addr=9'h0FF.
- PWM tear-free update:
  - Write channels 0..7 with 100..107 → pwm_out unchanged (0), pending=1.
  - pwm_commit=1 → all eight channels show 100..107 on the same cycle, pending=0.
- Commit + write collision: channel 2 holds 5 and pending=1; write channel 2 ← 9 with pwm_commit=1 → channel 2 shows 5, pending stays 1. Next commit → channel 2 shows 9.
- Reset mid-frame: pending=1, assert rst → pwm_out=0, pending=0. A following commit leaves pwm_out=0.
